// File: rtl/jump_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// jump_ctrl_pkg
//   Shared definitions for the jump controller: MIPS opcode/funct encodings for
//   the control-flow instructions it handles, the controller state encoding,
//   and the J-type target helper.
// -----------------------------------------------------------------------------
package jump_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,  // normal sequential fetch
    WAIT_RS = 2'd1,  // jr held in ID until its rs operand is forwarded-ready
    FLUSH   = 2'd2   // one bubble cycle after a taken redirect
  } state_e;

  // J-type target: region bits of pc+4 with the 26-bit word index.
  // Masking keeps the whole pc4 word in the expression.
  function automatic logic [31:0] jtype_target(input logic [31:0] pc4,
                                               input logic [25:0] tgt);
    return (pc4 & 32'hF000_0000) | {4'h0, tgt, 2'b00};
  endfunction

endpackage

// File: rtl/jump_ctrl_link_buf.sv
// -----------------------------------------------------------------------------
// jump_ctrl_link_buf
//   Single-entry buffer for the jal link value. The entry is written to the
//   register file only when writeback does not own the shared write port.
//   A new load in the same cycle as a drain replaces the drained value and
//   leaves the buffer full.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (discards any pending entry)
//   load_i       capture load_data_i this cycle
//   load_data_i  link value (pc+4 of the jal)
//   wb_we_i      writeback owns the regfile write port this cycle
//   we_o         regfile write enable for the buffered link
//   data_o       buffered link value
//   full_o       buffer holds an entry
// -----------------------------------------------------------------------------
module jump_ctrl_link_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        wb_we_i,
  output logic        we_o,
  output logic [31:0] data_o,
  output logic        full_o
);

  logic        full_q, full_d;
  logic [31:0] data_q, data_d;

  // Writeback has priority; no write fires in a cycle where reset is applied,
  // so a pending link is discarded rather than committed.
  assign we_o   = full_q & ~wb_we_i & rst_n;
  assign data_o = data_q;
  assign full_o = full_q;

  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    full_d = full_q;
    data_d = data_q;
    if (we_o) begin
      full_d = 1'b0;
    end
    // Load after drain so a same-cycle load wins and keeps the entry full.
    if (load_i) begin
      full_d = 1'b1;
      data_d = load_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data word is reset too so link_data reads 0 out of reset;
      // a single register costs nothing to reset, unlike a memory array.
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state so every
      // register samples the pre-edge value regardless of statement order.
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// -----------------------------------------------------------------------------
// jump_ctrl
//   Fetch-PC sequencer for control-flow instructions decoded in ID (j, jal,
//   jr). Redirects the PC and squashes the wrong-path fetch, holds jr in ID
//   until its rs operand is ready, and queues the jal link write ($ra) onto
//   the register-file write port shared with writeback.
//
// Ports
//   clk, rst_n     clock / synchronous active-low reset
//   stall_in       global pipeline hold (highest priority)
//   id_valid, id_opcode, id_funct, id_pc, id_target
//                  ID-stage instruction fields
//   id_rs_data     forwarded rs value, id_rs_ready marks it valid
//   wb_we          writeback owns the regfile write port this cycle
//   pc_out         fetch PC
//   if_flush       squash IF/ID this cycle (taken redirect)
//   id_stall       hold ID and IF/ID
//   link_we/link_addr/link_data   link write to the register file
//   jr_misaligned  pulse: jr target had nonzero low bits
//   redirect_cnt   saturating count of taken redirects
// -----------------------------------------------------------------------------
module jump_ctrl
  import jump_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  RA_REG   = 5'd31,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [5:0]       id_funct,
  input  logic [31:0]      id_pc,
  input  logic [25:0]      id_target,
  input  logic [31:0]      id_rs_data,
  input  logic             id_rs_ready,
  input  logic             wb_we,
  output logic [31:0]      pc_out,
  output logic             if_flush,
  output logic             id_stall,
  output logic             link_we,
  output logic [4:0]       link_addr,
  output logic [31:0]      link_data,
  output logic             jr_misaligned,
  output logic [CNT_W-1:0] redirect_cnt
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        is_j, is_jal, is_jr;
  logic        jr_path;
  logic [31:0] pc4, target;
  logic        take;
  logic        link_load, link_full;

  // ---------------------------------------------------------------------------
  // Decode and target generation
  // ---------------------------------------------------------------------------
  assign is_j   = id_valid && (id_opcode == OP_J);
  assign is_jal = id_valid && (id_opcode == OP_JAL);
  assign is_jr  = id_valid && (id_opcode == OP_RTYPE) && (id_funct == FUNCT_JR);

  // A jr parked in WAIT_RS stays a jr even if decode flickers.
  assign jr_path = (state_q == WAIT_RS) || is_jr;

  assign pc4    = id_pc + 32'd4;
  assign target = jr_path ? {id_rs_data[31:2], 2'b00} : jtype_target(pc4, id_target);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    if_flush      = 1'b0;
    id_stall      = 1'b0;
    jr_misaligned = 1'b0;
    link_load     = 1'b0;
    take          = 1'b0;

    if (!rst_n || stall_in) begin
      // Reset or global hold: everything freezes, pulses stay low.
      // The link buffer still drains on its own.
    end else begin
      unique case (state_q)
        RUN: begin
          if (is_jr && !id_rs_ready) begin
            id_stall = 1'b1;
            state_d  = WAIT_RS;
          end else if (is_jal && link_full && !link_we) begin
            // Buffer still occupied by the previous link and writeback
            // owns the port: the jal cannot claim the buffer yet.
            id_stall = 1'b1;
          end else if (is_j || is_jal || is_jr) begin
            take = 1'b1;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
        WAIT_RS: begin
          if (!id_rs_ready) begin
            id_stall = 1'b1;
          end else begin
            take = 1'b1;
          end
        end
        FLUSH: begin
          // ID holds the squashed bubble; id_valid is not looked at.
          pc_d    = pc_q + 32'd4;
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase

      if (take) begin
        pc_d          = target;
        if_flush      = 1'b1;
        state_d       = FLUSH;
        jr_misaligned = jr_path && (id_rs_data[1:0] != 2'b00);
        link_load     = !jr_path && is_jal;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Link buffer
  // ---------------------------------------------------------------------------
  jump_ctrl_link_buf u_link_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (link_load),
    .load_data_i (pc4),
    .wb_we_i     (wb_we),
    .we_o        (link_we),
    .data_o      (link_data),
    .full_o      (link_full)
  );

  assign link_addr    = RA_REG;
  assign pc_out       = pc_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jump_ctrl
//   Directed bench for jump_ctrl. Stimulus pushes the expected redirect and
//   link-write events into queues; a monitor pops and compares them whenever
//   the DUT asserts if_flush or link_we. Cycle-level values (stalls, held PC,
//   reset state) are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_jump_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          CW     = 8;   // small counter keeps saturation test short

  logic          clk, rst_n, stall_in, id_valid, id_rs_ready, wb_we;
  logic [5:0]    id_opcode, id_funct;
  logic [31:0]   id_pc, id_rs_data;
  logic [25:0]   id_target;
  logic [31:0]   pc_out, link_data;
  logic          if_flush, id_stall, link_we, jr_misaligned;
  logic [4:0]    link_addr;
  logic [CW-1:0] redirect_cnt;

  jump_ctrl #(.RESET_PC(RST_PC), .RA_REG(5'd31), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_pc(id_pc),
    .id_target(id_target), .id_rs_data(id_rs_data), .id_rs_ready(id_rs_ready),
    .wb_we(wb_we), .pc_out(pc_out), .if_flush(if_flush), .id_stall(id_stall),
    .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
    .jr_misaligned(jr_misaligned), .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic [31:0] cnt;
  } redir_t;

  redir_t      exp_redir[$];
  logic [31:0] exp_link[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops expectations when the DUT presents an event
  // ---------------------------------------------------------------------------
  initial begin
    redir_t      r;
    logic [31:0] l;
    forever begin
      @(negedge clk);
      if (link_we) begin
        if (exp_link.size() == 0) begin
          check("link_we_spurious", 32'(link_we), 32'd0);
        end else begin
          l = exp_link.pop_front();
          check("link_data", link_data, l);
          check("link_addr", 32'(link_addr), 32'd31);
        end
      end
      if (!if_flush) begin
        if (jr_misaligned) check("jr_mis_spurious", 32'(jr_misaligned), 32'd0);
      end else if (exp_redir.size() == 0) begin
        check("if_flush_spurious", 32'(if_flush), 32'd0);
      end else begin
        r = exp_redir.pop_front();
        check("jr_misaligned", 32'(jr_misaligned), 32'(r.mis));
        @(posedge clk); #1;
        check("redirect_pc", pc_out, r.pc);
        check("redirect_cnt", 32'(redirect_cnt), r.cnt);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    stall_in = 0; id_valid = 0; id_opcode = 6'd0; id_funct = 6'd0;
    id_pc = 32'd0; id_target = 26'd0; id_rs_data = 32'd0; id_rs_ready = 1;
  endtask

  task automatic drive_j(input logic [5:0] op, input logic [31:0] pc, input logic [25:0] tgt);
    id_valid = 1; id_opcode = op; id_funct = 6'd0; id_pc = pc; id_target = tgt;
  endtask

  task automatic drive_jr(input logic [31:0] rs, input logic rdy);
    id_valid = 1; id_opcode = 6'b000000; id_funct = 6'b001000;
    id_rs_data = rs; id_rs_ready = rdy;
  endtask

  task automatic push_redir(input logic [31:0] pc, input logic mis, input logic [31:0] cnt);
    redir_t r;
    r.pc = pc; r.mis = mis; r.cnt = cnt;
    exp_redir.push_back(r);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    wb_we = 0;
    rst_n = 0;

    // 1. Reset state, then three free-running cycles.
    tick(); tick();
    check("rst_pc", pc_out, RST_PC);
    check("rst_if_flush", 32'(if_flush), 0);
    check("rst_id_stall", 32'(id_stall), 0);
    check("rst_link_we", 32'(link_we), 0);
    check("rst_link_addr", 32'(link_addr), 31);
    check("rst_link_data", link_data, 0);
    check("rst_cnt", 32'(redirect_cnt), 0);
    check("rst_jr_mis", 32'(jr_misaligned), 0);
    rst_n = 1;
    tick(); tick(); tick();
    check("free_run_pc", pc_out, 32'h0040_000C);

    // 2. j: target {pc4[31:28], 0x100, 00} = 0x1000_0400.
    drive_j(6'b000010, 32'h1000_0008, 26'h000_0100);
    push_redir(32'h1000_0400, 0, 1);
    #1 check("j_if_flush", 32'(if_flush), 1);
    check("j_id_stall", 32'(id_stall), 0);
    tick();                                    // FLUSH: j still presented, ignored
    #1 check("flush_ignores_id", 32'(if_flush), 0);
    tick();
    check("flush_pc_inc", pc_out, 32'h1000_0404);
    idle();

    // 3. jal with writeback owning the port; second jal blocks until drain.
    wb_we = 1;
    drive_j(6'b000011, 32'h0040_0010, 26'h010_0040); // target 0x0040_0100
    push_redir(32'h0040_0100, 0, 2);
    exp_link.push_back(32'h0040_0014);
    tick();                                    // FLUSH, buffer full
    idle();
    #1 check("jal_link_held_a", 32'(link_we), 0);
    tick();                                    // RUN, pc 0x0040_0104
    drive_j(6'b000011, 32'h0040_0200, 26'h000_0010); // target 0x0000_0040
    #1 check("jal2_stall_a", 32'(id_stall), 1);
    check("jal_link_held_b", 32'(link_we), 0);
    tick();
    check("jal2_pc_hold_a", pc_out, 32'h0040_0104);
    check("jal2_stall_b", 32'(id_stall), 1);
    tick();
    check("jal2_pc_hold_b", pc_out, 32'h0040_0104);
    wb_we = 0;                                 // drain + load same cycle
    push_redir(32'h0000_0040, 0, 3);
    exp_link.push_back(32'h0040_0204);
    #1 check("jal2_released", 32'(id_stall), 0);
    check("jal2_flush", 32'(if_flush), 1);
    tick();                                    // FLUSH, second link drains
    idle();
    tick();                                    // RUN, pc 0x44
    check("link_empty", 32'(link_we), 0);

    // 4. jr waits three cycles for rs, then redirects misaligned to 0x2000.
    drive_jr(32'h0000_2002, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("jr_wait_stall", 32'(id_stall), 1);
      tick();
      check("jr_wait_pc", pc_out, 32'h0000_0044);
    end
    id_rs_ready = 1;
    push_redir(32'h0000_2000, 1, 4);
    #1 check("jr_go_stall", 32'(id_stall), 0);
    tick();
    idle();
    #1 check("jr_mis_once", 32'(jr_misaligned), 0);
    tick();
    check("jr_after_pc", pc_out, 32'h0000_2004);

    // 5. stall_in during FLUSH (link drains) and during WAIT_RS.
    wb_we = 1;
    drive_j(6'b000011, 32'h0000_3000, 26'h000_0800); // target 0x0000_2000
    push_redir(32'h0000_2000, 0, 5);
    exp_link.push_back(32'h0000_3004);
    tick();                                    // FLUSH, buffer full
    idle();
    wb_we = 0;
    stall_in = 1;
    #1 check("stl_fl_if_flush", 32'(if_flush), 0);
    check("stl_fl_id_stall", 32'(id_stall), 0);
    tick();
    check("stl_fl_pc", pc_out, 32'h0000_2000);
    check("stl_fl_cnt", 32'(redirect_cnt), 5);
    stall_in = 0;
    drive_j(6'b000010, 32'h0000_0000, 26'h000_0100); // still FLUSH: ignored
    #1 check("stl_fl_state", 32'(if_flush), 0);
    tick();
    check("stl_fl_pc_inc", pc_out, 32'h0000_2004);
    idle();
    drive_jr(32'h0000_5000, 0);
    tick();                                    // WAIT_RS
    stall_in = 1;
    id_rs_ready = 1;
    #1 check("stl_ws_if_flush", 32'(if_flush), 0);
    check("stl_ws_id_stall", 32'(id_stall), 0);
    tick();
    check("stl_ws_pc", pc_out, 32'h0000_2004);
    check("stl_ws_cnt", 32'(redirect_cnt), 5);
    stall_in = 0;
    push_redir(32'h0000_5000, 0, 6);
    #1 check("stl_ws_resume", 32'(if_flush), 1);
    tick();
    idle();
    tick();
    check("stl_ws_after_pc", pc_out, 32'h0000_5004);

    // 6a. Reset in WAIT_RS with link buffer full: link discarded.
    wb_we = 1;
    drive_j(6'b000011, 32'h0000_6000, 26'h000_0010); // target 0x0000_0040
    push_redir(32'h0000_0040, 0, 7);
    tick();
    idle();
    tick();
    drive_jr(32'h0000_7000, 0);
    tick();                                    // WAIT_RS, buffer still full
    rst_n = 0;
    wb_we = 0;
    #1 check("rst_mid_link_we", 32'(link_we), 0);
    tick();
    rst_n = 1;
    idle();
    check("rst_mid_pc", pc_out, RST_PC);
    check("rst_mid_cnt", 32'(redirect_cnt), 0);
    check("rst_mid_stall", 32'(id_stall), 0);
    tick();
    check("rst_mid_run", pc_out, RST_PC + 32'd4);
    tick(); tick();

    // 6b. 2^CW + 2 redirects saturate the counter at all-ones.
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      drive_j(6'b000010, 32'h0000_0000, 26'h000_0010);
      push_redir(32'h0000_0040, 0, (i + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : i + 1);
      tick();
      idle();
      tick();
    end
    check("cnt_saturated", 32'(redirect_cnt), (1 << CW) - 1);

    tick(); tick();
    check("redir_queue_empty", exp_redir.size(), 0);
    check("link_queue_empty", exp_link.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
